// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding controller for the 5-stage RV32 pipeline.
// Drives front-end enables/flushes combinationally and registers EX forwarding selects.
module hazard_fwd_ctrl #(
  parameter int REG_AW   = 5,
  parameter int BR_EXTRA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_asel_pc,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_br_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        fsm_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_STALL = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  localparam logic [1:0] BR_LD = 2'(BR_EXTRA);

  state_t           r_state, w_state_next;
  logic [1:0]       r_rem, w_rem_next;
  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic       w_exm_a, w_exm_b, w_memm_a, w_memm_b;
  logic [1:0] w_sel_a, w_sel_b;
  logic       w_lu, w_br, w_stall_evt;

  // Register x0 is hard-wired zero, so it never participates in forwarding.
  assign w_exm_a  = ex_regwrite  && (ex_rd  == id_rs1) && (id_rs1 != '0);
  assign w_exm_b  = ex_regwrite  && (ex_rd  == id_rs2) && (id_rs2 != '0);
  assign w_memm_a = mem_regwrite && (mem_rd == id_rs1) && (id_rs1 != '0);
  assign w_memm_b = mem_regwrite && (mem_rd == id_rs2) && (id_rs2 != '0);

  always_comb begin
    w_sel_a = 2'b00;
    w_sel_b = 2'b00;
    if (id_use_rs1 && !id_asel_pc) begin
      if (w_exm_a)       w_sel_a = 2'b10;
      else if (w_memm_a) w_sel_a = 2'b01;
    end
    if (id_use_rs2) begin
      if (w_exm_b)       w_sel_b = 2'b10;
      else if (w_memm_b) w_sel_b = 2'b01;
    end
  end

  assign w_lu = ex_memread && ((w_exm_a && id_use_rs1 && !id_asel_pc) ||
                               (w_exm_b && id_use_rs2));
  assign w_br = ex_br_taken || (r_state == S_FLUSH);
  // A taken branch squashes the dependent instruction, so it outranks the stall.
  assign w_stall_evt = w_lu && !w_br;

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_br) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    case (r_state)
      S_RUN, S_STALL: begin
        if (ex_br_taken) begin
          if (BR_EXTRA > 0) begin
            w_state_next = S_FLUSH;
            w_rem_next   = BR_LD;
          end else begin
            w_state_next = S_RUN;
          end
        end else if (w_lu) begin
          w_state_next = S_STALL;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_FLUSH: begin
        if (ex_br_taken && (BR_EXTRA > 0)) begin
          w_rem_next = BR_LD;
        end else if (ex_br_taken || r_rem <= 2'd1) begin
          w_state_next = S_RUN;
          w_rem_next   = 2'd0;
        end else begin
          w_rem_next = r_rem - 2'd1;
        end
      end
      default: begin
        w_state_next = S_RUN;
        w_rem_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_rem       <= 2'd0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      r_fwd_a <= idex_flush ? 2'b00 : w_sel_a;
      r_fwd_b <= idex_flush ? 2'b00 : w_sel_b;
      if (w_stall_evt && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_br && !(&r_flush_cnt))        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
  assign fsm_state = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
